// File: rtl/xillybus_loopback_fifo_32_pkg.sv
// Shared types for the Xillybus user-side endpoints: the loopback stream state and the bus width.
package xillybus_user_pkg;
  localparam int XB_DW = 32;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    EOF
  } lb_state_t;
endpackage

// File: rtl/xillybus_loopback_fifo_32_if.sv
// One 32-bit Xillybus stream pair plus status; master is the core side, slave is the user endpoint.
interface xillybus_loopback_fifo_32_if
  import xillybus_user_pkg::*;
#(
  parameter int DEPTH = 512
) ();
  localparam int AW = $clog2(DEPTH);

  logic             user_w_write_32_wren;
  logic [XB_DW-1:0] user_w_write_32_data;
  logic             user_w_write_32_full;
  logic             user_w_write_32_open;
  logic             user_r_read_32_rden;
  logic [XB_DW-1:0] user_r_read_32_data;
  logic             user_r_read_32_empty;
  logic             user_r_read_32_eof;
  logic             user_r_read_32_open;
  logic [AW:0]      fill_level;
  logic             overflow;

  modport master (
    output user_w_write_32_wren, user_w_write_32_data, user_w_write_32_open,
    output user_r_read_32_rden, user_r_read_32_open,
    input  user_w_write_32_full, user_r_read_32_data, user_r_read_32_empty,
    input  user_r_read_32_eof, fill_level, overflow
  );

  modport slave (
    input  user_w_write_32_wren, user_w_write_32_data, user_w_write_32_open,
    input  user_r_read_32_rden, user_r_read_32_open,
    output user_w_write_32_full, user_r_read_32_data, user_r_read_32_empty,
    output user_r_read_32_eof, fill_level, overflow
  );
endinterface

// File: rtl/xillybus_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port; read data appears the cycle after re.
// No backpressure: every we/re is honoured; rdata holds its value when re is low.
module xillybus_sdp_ram #(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/xillybus_loopback_fifo_32.sv
// Loopback FIFO between a Xillybus write and read stream with open/close tracking and eof; read data 1 cycle after rden.
// Backpressure: full at DEPTH words or while eof is presented; strobes against full/empty are dropped.
module xillybus_loopback_fifo_32
  import xillybus_user_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input  logic                         bus_clk,
  input  logic                         bus_rst,
  xillybus_loopback_fifo_32_if.slave   xb
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  lb_state_t     state, state_nxt;
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          overflow_q;
  logic          full, empty, push, pop, flush;

  assign full  = (count == FULL_CNT) | (state == EOF);
  assign empty = (count == '0);
  assign push  = xb.user_w_write_32_wren & ~full;
  assign pop   = xb.user_r_read_32_rden & ~empty;
  // Both files closed outside an active stream: nothing will ever read the leftovers.
  assign flush = ~xb.user_r_read_32_open & ~xb.user_w_write_32_open & (state != STREAM);

  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      state      <= IDLE;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (xb.user_w_write_32_wren & full) overflow_q <= 1'b1;
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (xb.user_w_write_32_open) state_nxt = STREAM;
      STREAM: if (!xb.user_w_write_32_open) state_nxt = DRAIN;
      // A writer reopening before the drain finishes cancels the pending eof.
      DRAIN: begin
        if (xb.user_w_write_32_open) state_nxt = STREAM;
        else if (count == '0)        state_nxt = EOF;
      end
      EOF:    if (!xb.user_r_read_32_open) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  xillybus_sdp_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (XB_DW)
  ) u_ram (
    .clk   (bus_clk),
    .rst   (bus_rst),
    .we    (push),
    .waddr (wptr),
    .wdata (xb.user_w_write_32_data),
    .re    (pop),
    .raddr (rptr),
    .rdata (xb.user_r_read_32_data)
  );

  assign xb.user_w_write_32_full = full;
  assign xb.user_r_read_32_empty = empty;
  assign xb.user_r_read_32_eof   = (state == EOF);
  assign xb.fill_level           = count;
  assign xb.overflow             = overflow_q;
endmodule

// File: doc/xillybus_loopback_fifo_32.md
Name: xillybus_loopback_fifo_32

Overview:
User-side endpoint for one 32-bit Xillybus stream pair. It sinks the core's host-to-FPGA write stream (user_w_write_32_*) into a buffer and sources the core's FPGA-to-host read stream (user_r_read_32_*) from the same buffer. It produces full, empty and eof, and tracks file open/close on both sides. It sits in the user application next to the core, on bus_clk.

Parameters:
DEPTH, 512, buffer depth in 32-bit words; power of two, at least 4
AW, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
bus_clk  in  1  system clock shared with the core
bus_rst  in  1  synchronous active-high reset
user_w_write_32_wren  in  1  write strobe from core
user_w_write_32_data  in  32  write data from core
user_w_write_32_full  out  1  backpressure to core
user_w_write_32_open  in  1  host write file open
user_r_read_32_rden  in  1  read strobe from core
user_r_read_32_data  out  32  read data, valid the cycle after an accepted rden
user_r_read_32_empty  out  1  no word available
user_r_read_32_eof  out  1  end-of-file to the core; meaningful only while empty=1
user_r_read_32_open  in  1  host read file open
fill_level  out  AW+1  current word count
overflow  out  1  sticky: wren was seen while full=1

Behaviour:
- Reset (bus_rst=1 at a clock edge): pointers=0, count=0, state=IDLE, read data=0, overflow=0. After reset, full=0, empty=1, eof=0, fill_level=0.
- Push: wren & !full writes data at wptr; wptr wraps modulo DEPTH.
- Pop: rden & !empty reads at rptr. The output data register updates at the next edge (1-cycle latency) and holds its value otherwise.
- Rejected strobes:
  - wren while full is dropped and sets overflow.
  - rden while empty is ignored; data register unchanged.
- Simultaneous accepted push and pop: count unchanged. At count=DEPTH only pop is accepted; at count=0 only push is accepted.
- Flag timing: full = (count==DEPTH) | (state==EOF); empty = (count==0). Both are registered-count based, so a push is visible at the read side one cycle later.
- State machine (registered):
  - IDLE: write_open=0. write_open=1 -> STREAM.
  - STREAM: write_open falls -> DRAIN.
  - DRAIN: count==0 -> EOF. If write_open rises again before drain completes -> STREAM (no eof generated).
  - EOF: eof=1 and full forced 1. Leaves only when read_open=0 -> IDLE.
- eof is 1 only in EOF, where count is 0, so empty=1 always accompanies it.
- Flush: read_open low in any state while write_open=0 and state is not STREAM resets pointers/count to 0 in one cycle. Data written while the reader is closed but the writer is open is retained.
- Reader reopen: opening the reader while in IDLE with buffered data delivers that data.
- Reset mid-operation: all buffered data is discarded; the same values as the reset state apply.

Decomposition:
- Package xillybus_user_pkg holds:
  - enum lb_state_t {IDLE, STREAM, DRAIN, EOF}
  - localparam XB_DW=32
- Sub-module xillybus_sdp_ram: simple dual-port RAM, one write port, registered read port, DEPTH x 32.
- The FIFO control and FSM stay in this module.

Test Plan:
- Reset, then open both sides; write 0x11111111, 0x22222222, 0x33333333, then rden x3 -> data 0x11111111/0x22222222/0x33333333 each one cycle after its rden; empty=1 after the third pop; fill_level 3->0.
- Fill with DEPTH words, then wren with 0xDEADBEEF -> full=1, word dropped, overflow=1 sticky. Pop all -> last word read is word DEPTH-1, not 0xDEADBEEF.
- Wraparound: interleave 3*DEPTH pushes/pops, with simultaneous push+pop while count=5 -> in-order data, fill_level stays 5 during simultaneous cycles.
- Writer closes with 4 words buffered -> eof=0 until the fourth pop, then empty=1 & eof=1 next cycle and full=1. Reader closes -> eof=0, full=0, state IDLE.
- Writer close then reopen after 2 of 4 words drained -> eof never asserts; remaining 2 words plus new words delivered in order.
- Both files open, 7 words buffered, writer closes, reader closes -> fill_level=0 next cycle. Assert bus_rst mid-stream -> full=0, empty=1, eof=0, overflow=0.
